// File: rtl/demux_8nton_reg.sv
// demux_8nton_reg
// ---------------
// Registered 1:8 demultiplexer. One N-bit word per cycle enters on a
// valid/ready handshake and is steered by S into one of eight single-entry
// output lanes, each with its own valid/ready handshake towards its consumer.
// It is the distribution-side partner of the N-bit 8:1 select mux and fans a
// result/operand bus out to eight independently back-pressured consumers.
//
// Ports:
//   clk        in   1    clock, all state changes on the rising edge
//   rst        in   1    synchronous active-high reset
//   en         in   1    enable; 0 blocks new input acceptance (drains continue)
//   I          in   N    input data word
//   S          in   3    destination lane select
//   in_valid   in   1    input word present
//   in_ready   out  1    block can accept a word this cycle
//   O0..O7     out  N    lane data, forced to 0 while that lane is empty
//   out_valid  out  8    bit k set when lane k holds a word
//   out_ready  in   8    bit k set when consumer k takes the lane-k word
//   count      out  CW   words accepted since reset, wraps modulo 2^CW

module demux_8nton_reg #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  I,
  input  logic [2:0]    S,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  O0,
  output logic [N-1:0]  O1,
  output logic [N-1:0]  O2,
  output logic [N-1:0]  O3,
  output logic [N-1:0]  O4,
  output logic [N-1:0]  O5,
  output logic [N-1:0]  O6,
  output logic [N-1:0]  O7,
  output logic [7:0]    out_valid,
  input  logic [7:0]    out_ready,
  output logic [CW-1:0] count
);

  logic [N-1:0]  lane_q [8];
  logic [N-1:0]  lane_d [8];
  logic [7:0]    valid_q;
  logic [7:0]    valid_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          accept;

  // The selected lane can take a word when it is empty or is being drained
  // this very cycle, which gives one word per cycle into an always-ready
  // consumer. in_valid deliberately plays no part here.
  always_comb begin
    in_ready = en & ~rst & (~valid_q[S] | out_ready[S]);
    accept   = in_valid & in_ready;
  end

  // Next-state: every lane whose consumer is ready drops its valid; an accept
  // then overrides the selected lane, so a same-cycle drain and refill keeps
  // the lane full with the new word.
  always_comb begin
    lane_d  = lane_q;
    valid_d = valid_q & ~out_ready;
    count_d = count_q;
    if (accept) begin
      lane_d[S]  = I;
      valid_d[S] = 1'b1;
      count_d    = count_q + CW'(1);
    end
  end

  // State registers; reset discards every held word and any word offered in
  // the reset cycle (in_ready is already low then, so nothing is accepted).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        lane_q[k] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      lane_q  <= lane_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  // An unknown select while a word is offered would corrupt lane routing.
  always_ff @(posedge clk) begin
    if (!rst && in_valid && en) begin
      assert (!$isunknown(S));
    end
  end

  // Empty lanes present zero so stale data is never visible downstream.
  always_comb begin
    O0 = valid_q[0] ? lane_q[0] : '0;
    O1 = valid_q[1] ? lane_q[1] : '0;
    O2 = valid_q[2] ? lane_q[2] : '0;
    O3 = valid_q[3] ? lane_q[3] : '0;
    O4 = valid_q[4] ? lane_q[4] : '0;
    O5 = valid_q[5] ? lane_q[5] : '0;
    O6 = valid_q[6] ? lane_q[6] : '0;
    O7 = valid_q[7] ? lane_q[7] : '0;
  end

  assign out_valid = valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_demux_8nton_reg.sv
// tb_demux_8nton_reg
// ------------------
// Directed bench for demux_8nton_reg. A 32/16 instance carries the main
// checks; a second instance with CW=4 shares every input so counter wrap can
// be observed after a modest number of accepts.

module tb_demux_8nton_reg;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] data_in;
  logic [2:0]  sel;
  logic        in_valid;
  logic [7:0]  out_ready;

  logic        in_ready;
  logic [31:0] o [8];
  logic [7:0]  out_valid;
  logic [15:0] count;

  logic        in_ready4;
  logic [31:0] o4 [8];
  logic [7:0]  out_valid4;
  logic [3:0]  count4;

  int checks;
  int failures;

  demux_8nton_reg #(.N(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .I(data_in), .S(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .O0(o[0]), .O1(o[1]), .O2(o[2]), .O3(o[3]),
    .O4(o[4]), .O5(o[5]), .O6(o[6]), .O7(o[7]),
    .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  demux_8nton_reg #(.N(32), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .I(data_in), .S(sel),
    .in_valid(in_valid), .in_ready(in_ready4),
    .O0(o4[0]), .O1(o4[1]), .O2(o4[2]), .O3(o4[3]),
    .O4(o4[4]), .O5(o4[5]), .O6(o4[6]), .O7(o4[7]),
    .out_valid(out_valid4), .out_ready(out_ready), .count(count4)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic [2:0]  s;
    logic [31:0] data;
    logic        in_valid;
    logic [7:0]  out_ready;
    logic        exp_ready;
    logic [7:0]  exp_valid;
    logic [15:0] exp_count;
    logic [31:0] exp_lane;
  } vec_t;

  vec_t vecs [18];

  // Compare one observed value with its expected value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs (reset deasserted).
  task automatic applyStimulus(input logic e, input logic [2:0] s,
                               input logic [31:0] d, input logic v,
                               input logic [7:0] r);
    rst       = 1'b0;
    en        = e;
    sel       = s;
    data_in   = d;
    in_valid  = v;
    out_ready = r;
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] words [8];
    checks   = 0;
    failures = 0;

    words[0] = 32'hE59F1020; words[1] = 32'hAA000004;
    words[2] = 32'h5224912A; words[3] = 32'h28A44EAF;
    words[4] = 32'hFADB6EDB; words[5] = 32'h122225A8;
    words[6] = 32'h500A9D49; words[7] = 32'hE895D275;

    // Routing: one word into each lane, consumers never ready.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{1'b1, 3'(i), words[i], 1'b1, 8'h00, 1'b1,
                  8'((16'd1 << (i + 1)) - 16'd1), 16'(i + 1), words[i]};
    end
    // Back-pressure on full lane 3: word offered but held off.
    vecs[8]  = '{1'b1, 3'd3, 32'hDEADBEEF, 1'b1, 8'h00, 1'b0, 8'hFF, 16'd8,  32'h28A44EAF};
    // Drain lane 5 only; it reads 0 afterwards.
    vecs[9]  = '{1'b1, 3'd5, 32'h0,        1'b0, 8'h20, 1'b1, 8'hDF, 16'd8,  32'h0};
    // Lane 5 now empty: ready straight away and accepts.
    vecs[10] = '{1'b1, 3'd5, 32'h00000055, 1'b1, 8'h00, 1'b1, 8'hFF, 16'd9,  32'h00000055};
    // Streaming into full lane 2 with its consumer always ready.
    vecs[11] = '{1'b1, 3'd2, 32'd1,        1'b1, 8'h04, 1'b1, 8'hFF, 16'd10, 32'd1};
    vecs[12] = '{1'b1, 3'd2, 32'd2,        1'b1, 8'h04, 1'b1, 8'hFF, 16'd11, 32'd2};
    vecs[13] = '{1'b1, 3'd2, 32'd3,        1'b1, 8'h04, 1'b1, 8'hFF, 16'd12, 32'd3};
    vecs[14] = '{1'b1, 3'd2, 32'd4,        1'b1, 8'h04, 1'b1, 8'hFF, 16'd13, 32'd4};
    // Consumer stops: lane 2 holds the last word and blocks.
    vecs[15] = '{1'b1, 3'd2, 32'd9,        1'b1, 8'h00, 1'b0, 8'hFF, 16'd13, 32'd4};
    // Disabled: no accept, count frozen, lanes untouched.
    vecs[16] = '{1'b0, 3'd1, 32'h12345678, 1'b1, 8'h00, 1'b0, 8'hFF, 16'd13, 32'hAA000004};
    // Disabled but every consumer ready: all lanes drain.
    vecs[17] = '{1'b0, 3'd1, 32'h12345678, 1'b1, 8'hFF, 1'b0, 8'h00, 16'd13, 32'h0};

    // Reset for two cycles.
    rst = 1'b1; en = 1'b1; sel = 3'd0; data_in = '0; in_valid = 1'b0; out_ready = 8'h00;
    tick();
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    tick();

    // Idle after reset.
    applyStimulus(1'b1, 3'd0, 32'h0, 1'b0, 8'h00);
    #1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    tick();
    checkOutput("idle_out_valid", 32'(out_valid), 32'h00);
    checkOutput("idle_count", 32'(count), 32'd0);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("idle_O%0d", k), o[k], 32'h0);
    end

    // Table-driven section.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].en, vecs[i].s, vecs[i].data, vecs[i].in_valid, vecs[i].out_ready);
      #1;
      checkOutput($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      tick();
      checkOutput($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("v%0d_O%0d", i, vecs[i].s), o[vecs[i].s], vecs[i].exp_lane);
    end

    // Every lane masked to zero after the full drain.
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("drained_O%0d", k), o[k], 32'h0);
      checkOutput($sformatf("drained4_O%0d", k), o4[k], 32'h0);
    end

    // Refill all lanes, then reset mid-operation with a word on offer.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), words[i], 1'b1, 8'h00);
      tick();
    end
    checkOutput("refill_out_valid", 32'(out_valid), 32'hFF);
    checkOutput("refill_count", 32'(count), 32'd21);
    rst = 1'b1; sel = 3'd0; data_in = 32'hCAFEF00D; in_valid = 1'b1; out_ready = 8'h00;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("midrst_out_valid", 32'(out_valid), 32'h00);
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_count4", 32'(count4), 32'd0);
    checkOutput("midrst_O0", o[0], 32'h0);
    applyStimulus(1'b1, 3'd0, 32'h0, 1'b0, 8'h00);
    tick();
    checkOutput("postrst_out_valid", 32'(out_valid), 32'h00);
    checkOutput("postrst_count", 32'(count), 32'd0);

    // 17 back-to-back accepts into lane 0: the 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 3'd0, 32'(i + 100), 1'b1, 8'hFF);
      tick();
    end
    applyStimulus(1'b1, 3'd0, 32'h0, 1'b0, 8'h00);
    checkOutput("wrap_count4", 32'(count4), 32'd1);
    checkOutput("wrap_count", 32'(count), 32'd17);
    checkOutput("wrap_O0", o[0], 32'd116);
    checkOutput("wrap_out_valid4", 32'(out_valid4), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
